// File: rtl/hidden_delta_scheduler.sv
// Hidden-layer back-propagation controller: one shared signed multiplier walks
// delta1[k]*w[k][j] per hidden neuron, then scales by sigmoid-prime and saturates.
module hidden_delta_scheduler #(
    parameter int N_HID = 5,
    parameter int N_OUT = 3,
    parameter int DW    = 10,
    parameter int SCALE = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [N_OUT*DW-1:0]       delta1_in,
    input  logic [N_OUT*N_HID*DW-1:0] weight_in,
    input  logic [N_HID*DW-1:0]       sp_in,
    output logic                      busy,
    output logic                      done,
    output logic [N_HID*DW-1:0]       delta0_out
);

    localparam int PW  = 2 * DW;
    localparam int ACW = 2 * DW + 4;
    localparam int RW  = ACW + DW + 1;
    localparam int KW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int JW  = (N_HID > 1) ? $clog2(N_HID) : 1;

    localparam logic [KW-1:0]        K_LAST  = KW'(N_OUT - 1);
    localparam logic [JW-1:0]        J_LAST  = JW'(N_HID - 1);
    localparam logic signed [RW-1:0] SCALE_S = RW'(SCALE);
    localparam logic signed [RW-1:0] MAX_S   = RW'(2 ** (DW - 1) - 1);
    localparam logic signed [RW-1:0] MIN_S   = RW'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {IDLE, MAC, SCL, FIN} state_t;

    state_t state, state_nx;

    logic signed [DW-1:0]  d1_r  [N_OUT];
    logic signed [DW-1:0]  w_r   [N_OUT][N_HID];
    logic        [DW-1:0]  sp_r  [N_HID];
    logic signed [DW-1:0]  res_w [N_HID];
    logic        [KW-1:0]  k;
    logic        [JW-1:0]  j;
    logic signed [ACW-1:0] acc;

    logic signed [PW-1:0]  prod;
    logic signed [ACW-1:0] acc_sum;
    logic signed [RW-1:0]  scaled;
    logic signed [RW-1:0]  quot;
    logic signed [DW-1:0]  sat;

    // Handshake: start is taken only in IDLE; busy spans the start edge up to the
    // edge that raises the single-cycle done pulse together with delta0_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = MAC;
            MAC: begin
                if (abort)            state_nx = IDLE;
                else if (k == K_LAST) state_nx = SCL;
            end
            SCL: begin
                if (abort)            state_nx = IDLE;
                else if (j == J_LAST) state_nx = FIN;
                else                  state_nx = MAC;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Division by the signed constant truncates toward zero, as required for negatives.
    always_comb begin
        prod    = PW'(d1_r[k]) * PW'(w_r[k][j]);
        acc_sum = acc + ACW'(prod);
        scaled  = RW'(acc) * RW'($signed({1'b0, sp_r[j]}));
        quot    = scaled / SCALE_S;
        if (quot > MAX_S)      sat = MAX_S[DW-1:0];
        else if (quot < MIN_S) sat = MIN_S[DW-1:0];
        else                   sat = quot[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            delta0_out <= '0;
            k          <= '0;
            j          <= '0;
            acc        <= '0;
            for (int a = 0; a < N_OUT; a++) begin
                d1_r[a] <= '0;
                for (int b = 0; b < N_HID; b++) w_r[a][b] <= '0;
            end
            for (int b = 0; b < N_HID; b++) begin
                sp_r[b]  <= '0;
                res_w[b] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int a = 0; a < N_OUT; a++) begin
                            d1_r[a] <= delta1_in[a*DW +: DW];
                            for (int b = 0; b < N_HID; b++)
                                w_r[a][b] <= weight_in[(a*N_HID + b)*DW +: DW];
                        end
                        for (int b = 0; b < N_HID; b++) sp_r[b] <= sp_in[b*DW +: DW];
                        k    <= '0;
                        j    <= '0;
                        acc  <= '0;
                        busy <= 1'b1;
                    end
                end
                MAC: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else begin
                        acc <= acc_sum;
                        k   <= k + KW'(1);
                    end
                end
                SCL: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else begin
                        res_w[j] <= sat;
                        acc      <= '0;
                        k        <= '0;
                        if (j != J_LAST) j <= j + JW'(1);
                    end
                end
                FIN: begin
                    for (int b = 0; b < N_HID; b++) delta0_out[b*DW +: DW] <= res_w[b];
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule
